// File: rtl/atm_session_ctrl.sv
// Keypad-driven session controller for the ATM core: assembles digits into requests, sequences them, and applies failed-attempt lockout.
// Optional idle-session timeout is compiled in with `define ATM_SESSION_TIMEOUT_EN.
module atm_session_ctrl #(
  parameter int RESP_WAIT      = 4,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        language_sel,
  input  logic        success,
  input  logic [15:0] balance,
  output logic [2:0]  operation,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic [15:0] amount,
  output logic [15:0] Newpin,
  output logic        language,
  output logic        req_valid,
  output logic        result_valid,
  output logic        result_ok,
  output logic [15:0] result_balance,
  output logic        locked,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ACC    = 4'd1,
    S_PIN    = 4'd2,
    S_MENU   = 4'd3,
    S_AMT    = 4'd4,
    S_NEWPIN = 4'd5,
    S_ISSUE  = 4'd6,
    S_RESULT = 4'd7,
    S_LOCK   = 4'd8
  } state_t;

  localparam int WW = (RESP_WAIT > 1) ? $clog2(RESP_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(RESP_WAIT - 1);
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam logic [FW-1:0] TRIES_MAX = FW'(MAX_TRIES);

  state_t        r_state, r_state_next;
  logic [3:0]    r_acc, r_acc_next;
  logic [15:0]   r_pin, r_pin_next;
  logic [15:0]   r_newpin, r_newpin_next;
  logic [15:0]   r_amount, r_amount_next;
  logic [2:0]    r_op, r_op_next;
  logic          r_lang, r_lang_next;
  logic [2:0]    r_dcnt, r_dcnt_next;
  logic [FW-1:0] r_fail, r_fail_next;
  logic          r_locked, r_locked_next;
  logic [WW-1:0] r_wait, r_wait_next;
  logic          r_res_ok, r_res_ok_next;
  logic [15:0]   r_res_bal, r_res_bal_next;

  logic          w_digit, w_enter, w_cancel, w_clear;
  logic          w_entry_state, w_abort, w_timeout;
  logic          w_room;
  logic [15:0]   w_amount_x10;
  logic [FW-1:0] w_fail_inc;

  // Places digit n (0 = first) into its BCD nibble, most significant first.
  function automatic logic [15:0] put_bcd(input logic [15:0] v, input logic [2:0] n,
                                          input logic [3:0] d);
    logic [15:0] r;
    r = v;
    case (n)
      3'd0:    r[15:12] = d;
      3'd1:    r[11:8]  = d;
      3'd2:    r[7:4]   = d;
      3'd3:    r[3:0]   = d;
      default: r = v;
    endcase
    return r;
  endfunction

  assign w_digit  = key_valid && (key_code <= 4'd9);
  assign w_enter  = key_valid && (key_code == 4'hA);
  assign w_cancel = key_valid && (key_code == 4'hB);
  assign w_clear  = key_valid && (key_code == 4'hC);
  assign w_room   = (r_dcnt < 3'd4);

  assign w_amount_x10 = (r_amount << 3) + (r_amount << 1) + {12'd0, key_code};
  assign w_fail_inc   = r_fail + FW'(1);

  assign w_entry_state = (r_state == S_IDLE) || (r_state == S_ACC) || (r_state == S_PIN) ||
                         (r_state == S_MENU) || (r_state == S_AMT) || (r_state == S_NEWPIN);
  assign w_abort = (w_cancel && w_entry_state) || w_timeout;

`ifdef ATM_SESSION_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_tcnt, r_tcnt_next;
  logic          w_timed;

  assign w_timed   = w_entry_state && (r_state != S_IDLE);
  assign w_timeout = w_timed && !key_valid && (r_tcnt == T_LAST);

  // Restarts on every key and every state change; idles at zero outside entry states.
  always_comb begin
    r_tcnt_next = '0;
    if (w_timed && !key_valid && (r_state_next == r_state))
      r_tcnt_next = r_tcnt + TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tcnt <= '0;
    else     r_tcnt <= r_tcnt_next;
  end
`else
  // Constant false; keeps the parameter referenced when sessions never expire.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    r_state_next   = r_state;
    r_acc_next     = r_acc;
    r_pin_next     = r_pin;
    r_newpin_next  = r_newpin;
    r_amount_next  = r_amount;
    r_op_next      = r_op;
    r_lang_next    = r_lang;
    r_dcnt_next    = r_dcnt;
    r_fail_next    = r_fail;
    r_locked_next  = r_locked;
    r_wait_next    = '0;
    r_res_ok_next  = r_res_ok;
    r_res_bal_next = r_res_bal;

    case (r_state)
      S_IDLE: begin
        if (w_digit) begin
          r_acc_next   = key_code;
          r_lang_next  = language_sel;
          r_state_next = S_ACC;
        end
      end
      S_ACC: begin
        if (w_digit) r_acc_next = key_code;
        else if (w_clear) begin
          r_acc_next  = '0;
          r_dcnt_next = '0;
        end else if (w_enter) begin
          r_dcnt_next  = '0;
          r_state_next = S_PIN;
        end
      end
      S_PIN: begin
        if (w_digit && w_room) begin
          r_pin_next  = put_bcd(r_pin, r_dcnt, key_code);
          r_dcnt_next = r_dcnt + 3'd1;
        end else if (w_clear) begin
          r_pin_next  = '0;
          r_dcnt_next = '0;
        end else if (w_enter && (r_dcnt == 3'd4)) begin
          r_state_next = S_MENU;
        end
      end
      S_MENU: begin
        if (w_digit && (key_code >= 4'd1) && (key_code <= 4'd4)) begin
          r_op_next = key_code[2:0];
        end else if (w_enter && (r_op != 3'd0)) begin
          r_dcnt_next = '0;
          case (r_op)
            3'd1: r_state_next = S_ISSUE;
            3'd4: begin
              r_newpin_next = '0;
              r_state_next  = S_NEWPIN;
            end
            default: begin
              r_amount_next = '0;
              r_state_next  = S_AMT;
            end
          endcase
        end
      end
      S_AMT: begin
        if (w_digit && w_room) begin
          r_amount_next = w_amount_x10;
          r_dcnt_next   = r_dcnt + 3'd1;
        end else if (w_clear) begin
          r_amount_next = '0;
          r_dcnt_next   = '0;
        end else if (w_enter && (r_amount != 16'd0)) begin
          r_state_next = S_ISSUE;
        end
      end
      S_NEWPIN: begin
        if (w_digit && w_room) begin
          r_newpin_next = put_bcd(r_newpin, r_dcnt, key_code);
          r_dcnt_next   = r_dcnt + 3'd1;
        end else if (w_clear) begin
          r_newpin_next = '0;
          r_dcnt_next   = '0;
        end else if (w_enter && (r_dcnt == 3'd4)) begin
          r_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Response is sampled on the last hold cycle; keys are dropped throughout.
        if (r_wait == WAIT_LAST) begin
          r_res_ok_next  = success;
          r_res_bal_next = balance;
          r_state_next   = S_RESULT;
        end else begin
          r_wait_next = r_wait + WW'(1);
        end
      end
      S_RESULT: begin
        if (r_res_ok) begin
          r_fail_next  = '0;
          r_op_next    = 3'd0;
          r_state_next = S_MENU;
          if (r_op == 3'd4) r_pin_next = r_newpin;
        end else begin
          r_fail_next = w_fail_inc;
          if (w_fail_inc == TRIES_MAX) begin
            r_locked_next = 1'b1;
            r_state_next  = S_LOCK;
          end else begin
            r_state_next = S_MENU;
          end
        end
      end
      S_LOCK:  r_state_next = S_LOCK;
      default: r_state_next = S_IDLE;
    endcase

    // Session abort wipes the request but leaves the fail history intact.
    if (w_abort) begin
      r_state_next  = S_IDLE;
      r_acc_next    = '0;
      r_pin_next    = '0;
      r_newpin_next = '0;
      r_amount_next = '0;
      r_op_next     = 3'd0;
      r_lang_next   = 1'b0;
      r_dcnt_next   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_pin     <= '0;
      r_newpin  <= '0;
      r_amount  <= '0;
      r_op      <= '0;
      r_lang    <= 1'b0;
      r_dcnt    <= '0;
      r_fail    <= '0;
      r_locked  <= 1'b0;
      r_wait    <= '0;
      r_res_ok  <= 1'b0;
      r_res_bal <= '0;
    end else begin
      r_state   <= r_state_next;
      r_acc     <= r_acc_next;
      r_pin     <= r_pin_next;
      r_newpin  <= r_newpin_next;
      r_amount  <= r_amount_next;
      r_op      <= r_op_next;
      r_lang    <= r_lang_next;
      r_dcnt    <= r_dcnt_next;
      r_fail    <= r_fail_next;
      r_locked  <= r_locked_next;
      r_wait    <= r_wait_next;
      r_res_ok  <= r_res_ok_next;
      r_res_bal <= r_res_bal_next;
    end
  end

  assign operation      = r_op;
  assign acc_num        = r_acc;
  assign pin            = r_pin;
  assign amount         = r_amount;
  assign Newpin         = r_newpin;
  assign language       = r_lang;
  assign req_valid      = (r_state == S_ISSUE);
  assign result_valid   = (r_state == S_RESULT);
  assign result_ok      = r_res_ok;
  assign result_balance = r_res_bal;
  assign locked         = r_locked;
  assign state_o        = r_state;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed self-checking bench for atm_session_ctrl (RESP_WAIT=4, MAX_TRIES=3, TIMEOUT_CYCLES=20).
module tb_atm_session_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        language_sel;
  logic        success;
  logic [15:0] balance;
  logic [2:0]  operation;
  logic [3:0]  acc_num;
  logic [15:0] pin, amount, Newpin;
  logic        language, req_valid, result_valid, result_ok, locked;
  logic [15:0] result_balance;
  logic [3:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_issue;

  atm_session_ctrl #(.RESP_WAIT(4), .MAX_TRIES(3), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .language_sel(language_sel), .success(success), .balance(balance),
    .operation(operation), .acc_num(acc_num), .pin(pin), .amount(amount),
    .Newpin(Newpin), .language(language), .req_valid(req_valid),
    .result_valid(result_valid), .result_ok(result_ok),
    .result_balance(result_balance), .locked(locked), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // Called at a negedge; presents one key for one cycle and returns at the next negedge.
  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  // Counts the remaining request cycles; returns at the first negedge with req_valid low.
  task automatic wait_issue(output int n);
    n = 0;
    while (req_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    language_sel = 1'b0; success = 1'b0; balance = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Balance enquiry
    success = 1'b1; balance = 16'd500;
    press(4'd5); press(4'hA);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    press(4'hA);
    check("bal_menu_state", 32'(state_o), 32'd3);
    check("bal_acc", 32'(acc_num), 32'd5);
    check("bal_pin", 32'(pin), 32'h1234);
    press(4'd1); press(4'hA);
    check("bal_op", 32'(operation), 32'd1);
    wait_issue(n_issue);
    check("bal_issue_cycles", 32'(n_issue), 32'd4);
    check("bal_result_valid", 32'(result_valid), 32'd1);
    check("bal_result_ok", 32'(result_ok), 32'd1);
    check("bal_result_balance", 32'(result_balance), 32'd500);
    @(negedge clk);
    check("bal_back_menu", 32'(state_o), 32'd3);
    check("bal_pulse_end", 32'(result_valid), 32'd0);
    check("bal_op_cleared", 32'(operation), 32'd0);

    // Withdraw 250, CANCEL during ISSUE must be dropped
    balance = 16'd250;
    press(4'd2); press(4'hA);
    check("wd_amt_state", 32'(state_o), 32'd4);
    press(4'd2); press(4'd5); press(4'd0);
    check("wd_amount", 32'(amount), 32'd250);
    press(4'hA);
    check("wd_issue_op", 32'(operation), 32'd2);
    press(4'hB);
    check("wd_cancel_ignored", 32'(state_o), 32'd6);
    check("wd_amount_held", 32'(amount), 32'd250);
    wait_issue(n_issue);
    check("wd_issue_rest", 32'(n_issue), 32'd3);
    check("wd_result_state", 32'(state_o), 32'd7);
    @(negedge clk);

    // Deposit: fifth and sixth digits ignored, then CANCEL from AMT
    press(4'd3); press(4'hA);
    repeat (5) press(4'd9);
    check("amt_max", 32'(amount), 32'd9999);
    press(4'd1);
    check("amt_still_max", 32'(amount), 32'd9999);
    press(4'hB);
    check("cancel_state", 32'(state_o), 32'd0);
    check("cancel_fields", {acc_num, operation, language, 8'd0, amount}, 32'd0);
    check("cancel_pins", {pin, Newpin}, 32'd0);

    // New session with language 1, CLEAR and short ENTER in PIN
    language_sel = 1'b1;
    press(4'd7);
    language_sel = 1'b0;
    check("s2_acc", 32'(acc_num), 32'd7);
    check("s2_language", 32'(language), 32'd1);
    press(4'hA);
    press(4'd1); press(4'd2); press(4'hA);
    check("pin_short_enter", 32'(state_o), 32'd2);
    press(4'hC);
    check("pin_clear", 32'(pin), 32'd0);
    press(4'd7); press(4'd7); press(4'd8); press(4'd8); press(4'hA);
    check("pin_7788", 32'(pin), 32'h7788);
    check("pin_to_menu", 32'(state_o), 32'd3);

    // Change PIN
    press(4'd4); press(4'hA);
    check("np_state", 32'(state_o), 32'd5);
    press(4'd9); press(4'd8); press(4'd7); press(4'd6);
    check("np_value", 32'(Newpin), 32'h9876);
    press(4'hA);
    wait_issue(n_issue);
    check("np_issue_cycles", 32'(n_issue), 32'd4);
    @(negedge clk);
    check("np_pin_updated", 32'(pin), 32'h9876);
    check("np_menu", 32'(state_o), 32'd3);

    // Three consecutive failures -> lockout
    success = 1'b0; balance = 16'd77;
    for (int t = 0; t < 3; t++) begin
      press(4'd1); press(4'hA);
      wait_issue(n_issue);
      check("fail_result_ok", 32'(result_ok), 32'd0);
      @(negedge clk);
      check("fail_state", 32'(state_o), (t == 2) ? 32'd8 : 32'd3);
      check("fail_locked", 32'(locked), (t == 2) ? 32'd1 : 32'd0);
    end
    press(4'd1); press(4'hA); press(4'hB);
    check("lock_no_req", 32'(req_valid), 32'd0);
    check("lock_held", 32'(state_o), 32'd8);
    rst = 1'b1;
    #1;
    check("lock_rst_clear", 32'(locked), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset asserted asynchronously in the middle of ISSUE
    success = 1'b1;
    press(4'd3); press(4'hA);
    repeat (4) press(4'd1);
    press(4'hA); press(4'd1); press(4'hA);
    press(4'h0);
    check("mid_issue_state", 32'(state_o), 32'd6);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_state", 32'(state_o), 32'd0);
    check("mid_rst_req", 32'(req_valid), 32'd0);
    check("mid_rst_fields", {acc_num, operation, 9'd0, pin}, 32'd0);
    check("mid_rst_result", {15'd0, result_ok, result_balance}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Inactivity in PIN
    press(4'd2); press(4'hA);
    check("to_in_pin", 32'(state_o), 32'd2);
`ifdef ATM_SESSION_TIMEOUT_EN
    repeat (19) @(negedge clk);
    check("to_before_limit", 32'(state_o), 32'd2);
    @(negedge clk);
    check("to_expired", 32'(state_o), 32'd0);
    check("to_acc_cleared", 32'(acc_num), 32'd0);
`else
    repeat (25) @(negedge clk);
    check("to_never", 32'(state_o), 32'd2);
    check("to_acc_kept", 32'(acc_num), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
